// File: rtl/vga_display_out.sv
// vga_display_out: raster timing generator and registered VGA pin stage.
// Counters go out to the pixel mux and overlay logic. The composed pixel
// comes back PIXEL_LATENCY cycles later. Blank and sync travel through a
// matching delay line so that they line up with that pixel at the pins.
module vga_display_out #(
   parameter int H_ACTIVE        = 1024,
   parameter int H_FP            = 24,
   parameter int H_SYNC          = 136,
   parameter int H_BP            = 160,
   parameter int V_ACTIVE        = 768,
   parameter int V_FP            = 3,
   parameter int V_SYNC          = 6,
   parameter int V_BP            = 29,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int PIXEL_LATENCY   = 2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [11:0] pixel_in,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        active_out,
   output logic        new_frame_out,
   output logic [5:0]  frame_count_out,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Sized copies of the timing points, so counter compares are width-exact
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Pin level of a deasserted sync; XOR with the raw sync gives the pin
   localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

   typedef struct packed {
      logic blank;
      logic hs;
      logic vs;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{blank: 1'b1, hs: 1'b0, vs: 1'b0};

   logic h_last;
   logic v_last;
   ctl_t ctl_raw;
   ctl_t ctl_pipe [PIXEL_LATENCY:1];
   ctl_t ctl_d;

   assign h_last = (hcount_out == H_LAST);
   assign v_last = (vcount_out == V_LAST);

   // Raster counters: h every cycle, v on h wrap, both wrap at frame end
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hcount_out <= '0;
         vcount_out <= '0;
      end else if (h_last) begin
         hcount_out <= '0;
         vcount_out <= v_last ? 10'd0 : vcount_out + 10'd1;
      end else begin
         hcount_out <= hcount_out + 11'd1;
      end
   end

   // Frame pulse marks a wrap into (0,0); the (0,0) right after reset is not one
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         new_frame_out   <= 1'b0;
         frame_count_out <= '0;
      end else begin
         new_frame_out <= h_last && v_last;
         if (h_last && v_last)
            frame_count_out <= frame_count_out + 6'd1;
      end
   end

   // Raw blank/sync decoded straight from the counter registers
   always_comb begin
      ctl_raw       = CTL_IDLE;
      ctl_raw.blank = (hcount_out >= H_ACT) || (vcount_out >= V_ACT);
      ctl_raw.hs    = (hcount_out >= HS_BEG) && (hcount_out < HS_END);
      ctl_raw.vs    = (vcount_out >= VS_BEG) && (vcount_out < VS_END);
   end

   assign active_out = ~ctl_raw.blank;

   // Delay line: stage k holds the raw controls from k cycles ago
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int k = 1; k <= PIXEL_LATENCY; k++)
            ctl_pipe[k] <= CTL_IDLE;
      end else begin
         ctl_pipe[1] <= ctl_raw;
         for (int k = 2; k <= PIXEL_LATENCY; k++)
            ctl_pipe[k] <= ctl_pipe[k-1];
      end
   end

   assign ctl_d = ctl_pipe[PIXEL_LATENCY];

   // Pin register: colour gated by delayed blank, syncs at configured polarity
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         {vga_r, vga_g, vga_b} <= 12'h000;
         vga_hs                <= SYNC_IDLE;
         vga_vs                <= SYNC_IDLE;
      end else begin
         {vga_r, vga_g, vga_b} <= ctl_d.blank ? 12'h000 : pixel_in;
         vga_hs                <= ctl_d.hs ^ SYNC_IDLE;
         vga_vs                <= ctl_d.vs ^ SYNC_IDLE;
      end
   end

endmodule

// File: tb/tb_vga_display_out.sv
// tb_vga_display_out: three instances (default timing, small timing,
// inverted sync polarity with longer latency) run side by side. A queue
// scoreboard per instance holds the expected pin word for every counter
// position, and a second queue holds the pixel stream that is returned
// PIXEL_LATENCY cycles later.
module tb_vga_display_out;

   localparam int HA  [3] = '{1024, 8, 1024};
   localparam int HF  [3] = '{24,   1, 24};
   localparam int HS  [3] = '{136,  2, 136};
   localparam int HB  [3] = '{160,  1, 160};
   localparam int VA  [3] = '{768,  4, 768};
   localparam int VF  [3] = '{3,    1, 3};
   localparam int VS  [3] = '{6,    1, 6};
   localparam int VB  [3] = '{29,   1, 29};
   localparam int LAT [3] = '{2,    2, 3};
   localparam int SAL [3] = '{1,    1, 0};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [11:0] pix [3];
   logic [10:0] hc  [3];
   logic [9:0]  vc  [3];
   logic        act [3];
   logic        nf  [3];
   logic [5:0]  fc  [3];
   logic [3:0]  r   [3];
   logic [3:0]  g   [3];
   logic [3:0]  b   [3];
   logic        hs  [3];
   logic        vs  [3];

   vga_display_out u_dut0 (
      .clk_in(clk), .rst_n_in(rst_n), .pixel_in(pix[0]),
      .hcount_out(hc[0]), .vcount_out(vc[0]), .active_out(act[0]),
      .new_frame_out(nf[0]), .frame_count_out(fc[0]),
      .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .vga_hs(hs[0]), .vga_vs(vs[0])
   );

   vga_display_out #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE_LOW(1), .PIXEL_LATENCY(2)
   ) u_dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .pixel_in(pix[1]),
      .hcount_out(hc[1]), .vcount_out(vc[1]), .active_out(act[1]),
      .new_frame_out(nf[1]), .frame_count_out(fc[1]),
      .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .vga_hs(hs[1]), .vga_vs(vs[1])
   );

   vga_display_out #(
      .SYNC_ACTIVE_LOW(0), .PIXEL_LATENCY(3)
   ) u_dut2 (
      .clk_in(clk), .rst_n_in(rst_n), .pixel_in(pix[2]),
      .hcount_out(hc[2]), .vcount_out(vc[2]), .active_out(act[2]),
      .new_frame_out(nf[2]), .frame_count_out(fc[2]),
      .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]), .vga_hs(hs[2]), .vga_vs(vs[2])
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model state (per instance) and scoreboard queues
   int          cyc;
   int          mh  [3];
   int          mv  [3];
   int          mfc [3];
   logic        mnf [3];
   logic [13:0] exp_q [3][$];
   logic [11:0] pix_q [3][$];

   // Edge-measurement state
   logic prev_hs0, prev_hs2, prev_vs1;
   int   fall_cnt0, last_fall0, rise_cnt2, last_rise2, last_vs_fall1, nf_cnt1, last_nf1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ht(int d);
      return HA[d] + HF[d] + HS[d] + HB[d];
   endfunction

   function automatic int vt(int d);
      return VA[d] + VF[d] + VS[d] + VB[d];
   endfunction

   function automatic logic idle_lvl(int d);
      return SAL[d] != 0;
   endfunction

   function automatic logic is_blank(int d, int h, int v);
      return (h >= HA[d]) || (v >= VA[d]);
   endfunction

   // Pixel returned for (h,v): coordinate tag, with an all-ones window on line 0
   // straddling the end of the active area
   function automatic logic [11:0] gen_pix(int d, int h, int v);
      logic [10:0] hh;
      logic [9:0]  vv;
      hh = 11'(h);
      vv = 10'(v);
      if (v == 0 && h >= HA[d] - 8 && h < HA[d] + 16) return 12'hFFF;
      return {hh[3:0], vv[3:0], 4'h5};
   endfunction

   // Expected pin word {rgb, hs, vs} for counter position (h,v) and its pixel
   function automatic logic [13:0] exp_pins(int d, int h, int v, logic [11:0] p);
      logic hsr, vsr;
      hsr = (h >= HA[d] + HF[d]) && (h < HA[d] + HF[d] + HS[d]);
      vsr = (v >= VA[d] + VF[d]) && (v < VA[d] + VF[d] + VS[d]);
      return {is_blank(d, h, v) ? 12'h000 : p,
              idle_lvl(d) ? ~hsr : hsr,
              idle_lvl(d) ? ~vsr : vsr};
   endfunction

   task automatic chk_reset(input int d, input string what);
      chk($sformatf("d%0d %s hcount", d, what), hc[d], 0);
      chk($sformatf("d%0d %s vcount", d, what), vc[d], 0);
      chk($sformatf("d%0d %s rgb", d, what), {r[d], g[d], b[d]}, 0);
      chk($sformatf("d%0d %s hs", d, what), hs[d], idle_lvl(d));
      chk($sformatf("d%0d %s vs", d, what), vs[d], idle_lvl(d));
      chk($sformatf("d%0d %s new_frame", d, what), nf[d], 0);
      chk($sformatf("d%0d %s frame_count", d, what), fc[d], 0);
   endtask

   task automatic mdl_reset();
      cyc = 0;
      for (int d = 0; d < 3; d++) begin
         mh[d] = 0; mv[d] = 0; mfc[d] = 0; mnf[d] = 1'b0;
         exp_q[d].delete();
         pix_q[d].delete();
         repeat (LAT[d]) pix_q[d].push_back(12'hFFF);
         repeat (LAT[d] + 1) exp_q[d].push_back({12'h000, idle_lvl(d), idle_lvl(d)});
      end
      prev_hs0 = 1'b1; prev_hs2 = 1'b0; prev_vs1 = 1'b1;
      fall_cnt0 = 0; last_fall0 = 0; rise_cnt2 = 0; last_rise2 = 0;
      last_vs_fall1 = -1; nf_cnt1 = 0; last_nf1 = 0;
   endtask

   // Compare this cycle against the model, then drive the pixel for this cycle
   task automatic cycle_check();
      logic [11:0] p;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d hcount", d), hc[d], mh[d]);
         chk($sformatf("d%0d vcount", d), vc[d], mv[d]);
         chk($sformatf("d%0d active", d), act[d], !is_blank(d, mh[d], mv[d]));
         chk($sformatf("d%0d new_frame", d), nf[d], mnf[d]);
         chk($sformatf("d%0d frame_count", d), fc[d], mfc[d]);
         chk($sformatf("d%0d pins", d), {r[d], g[d], b[d], hs[d], vs[d]}, exp_q[d].pop_front());
         p = gen_pix(d, mh[d], mv[d]);
         pix_q[d].push_back(p);
         pix[d] = pix_q[d].pop_front();
         exp_q[d].push_back(exp_pins(d, mh[d], mv[d], p));
      end
   endtask

   // Targeted timing points on top of the per-cycle scoreboard
   task automatic measure();
      if (cyc == 1) chk("d0 hcount after release", hc[0], 1);
      if (cyc == 1026) chk("d0 rgb last active px", {r[0], g[0], b[0]}, 12'hFFF);
      if (cyc == 1027) chk("d0 rgb first blank px", {r[0], g[0], b[0]}, 12'h000);
      if (cyc == 1344 + 100 + 3) chk("d0 rgb h100 v1", {r[0], g[0], b[0]}, 12'h415);
      // default timing hsync, active low, latency 2
      if (prev_hs0 && !hs[0]) begin
         if (fall_cnt0 == 0) chk("d0 hs first fall", cyc, 1048 + 3);
         else if (fall_cnt0 == 1) chk("d0 hs fall spacing", cyc - last_fall0, 1344);
         last_fall0 = cyc;
         fall_cnt0++;
      end
      if (!prev_hs0 && hs[0] && fall_cnt0 == 1) chk("d0 hs low width", cyc - last_fall0, 136);
      // active-high sync, latency 3
      if (!prev_hs2 && hs[2]) begin
         if (rise_cnt2 == 0) chk("d2 hs first rise", cyc, 1048 + 4);
         last_rise2 = cyc;
         rise_cnt2++;
      end
      if (prev_hs2 && !hs[2] && rise_cnt2 == 1) chk("d2 hs high width", cyc - last_rise2, 136);
      // small timing: vsync width, frame pulses, frame counter wrap
      if (prev_vs1 && !vs[1]) last_vs_fall1 = cyc;
      if (!prev_vs1 && vs[1] && last_vs_fall1 >= 0) chk("d1 vs low width", cyc - last_vs_fall1, 12);
      if (nf[1]) begin
         if (nf_cnt1 == 0) chk("d1 first new_frame", cyc, 84);
         else chk("d1 new_frame spacing", cyc - last_nf1, 84);
         last_nf1 = cyc;
         nf_cnt1++;
         if (nf_cnt1 == 63) chk("d1 frame_count 63", fc[1], 63);
         if (nf_cnt1 == 64) chk("d1 frame_count wrap", fc[1], 0);
      end
      prev_hs0 = hs[0];
      prev_hs2 = hs[2];
      prev_vs1 = vs[1];
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 3; d++) begin
         mnf[d] = (mh[d] == ht(d) - 1) && (mv[d] == vt(d) - 1);
         if (mnf[d]) mfc[d] = (mfc[d] + 1) % 64;
         if (mh[d] == ht(d) - 1) begin
            mh[d] = 0;
            mv[d] = (mv[d] == vt(d) - 1) ? 0 : mv[d] + 1;
         end else begin
            mh[d] = mh[d] + 1;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) pix[d] = 12'hFFF;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) chk_reset(d, "reset");
      rst_n = 1'b1;
      mdl_reset();
      for (int i = 0; i < 9000; i++) begin
         cycle_check();
         measure();
         if (mh[0] == 500 && mv[0] == 4) begin
            chk("d0 rgb nonzero before reset", ({r[0], g[0], b[0]} != 12'h000), 1);
            rst_n = 1'b0;
            #1;
            for (int d = 0; d < 3; d++) chk_reset(d, "async clear");
            @(posedge clk);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            mdl_reset();
            continue;
         end
         advance();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
